// File: rtl/trap_sequencer_pkg.sv
// Shared constants and types for the trap sequencer: CSR addresses, cause codes,
// mstatus bit positions, write-mode encodings and the sequencer state set.
package trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned CAUSE_ILLEGAL = 2;
  localparam int unsigned CAUSE_LFAULT  = 5;
  localparam int unsigned CAUSE_SFAULT  = 7;
  localparam int unsigned CAUSE_ECALL   = 11;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;

  typedef enum logic [1:0] {
    WSC_NONE  = 2'b00,
    WSC_WRITE = 2'b01,
    WSC_SET   = 2'b10,
    WSC_CLEAR = 2'b11
  } wsc_e;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    W_MSTATUS,
    W_MRET
  } state_e;

  typedef enum logic {
    EPC_CUR,
    EPC_NEXT
  } epc_sel_e;

endpackage

// File: rtl/trap_priority_enc.sv
// Combinational event prioritiser: picks the highest-priority trap or mret in
// the MEM stage and produces the cause, mepc source and mtval to record.
module trap_priority_enc
  import trap_sequencer_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] INT_CAUSE = 32'h8000000B
) (
  input  logic            inst_valid,
  input  logic            ecall,
  input  logic            illegal_inst,
  input  logic            l_fault,
  input  logic            s_fault,
  input  logic            mret,
  input  logic            interrupt,
  input  logic            mie,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] dmem_addr,
  output logic            take,
  output logic            is_mret,
  output logic [XLEN-1:0] cause,
  output epc_sel_e        epc_sel,
  output logic [XLEN-1:0] tval
);

  always_comb begin
    // NOTE: every output gets a default before the if-chain so no path leaves one unassigned (no latches).
    take    = 1'b0;
    is_mret = 1'b0;
    cause   = '0;
    epc_sel = EPC_CUR;
    tval    = '0;
    // An enabled interrupt pre-empts everything and is not tied to a valid instruction.
    if (interrupt && mie) begin
      take    = 1'b1;
      cause   = INT_CAUSE;
      epc_sel = EPC_NEXT;
    end else if (inst_valid) begin
      if (illegal_inst) begin
        take  = 1'b1;
        cause = XLEN'(CAUSE_ILLEGAL);
        tval  = XLEN'(inst);
      end else if (ecall) begin
        take  = 1'b1;
        cause = XLEN'(CAUSE_ECALL);
      end else if (l_fault) begin
        take  = 1'b1;
        cause = XLEN'(CAUSE_LFAULT);
        tval  = dmem_addr;
      end else if (s_fault) begin
        take  = 1'b1;
        cause = XLEN'(CAUSE_SFAULT);
        tval  = dmem_addr;
      end else if (mret) begin
        take    = 1'b1;
        is_mret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Sole driver of the CSR file write port: passes CSR-instruction writes through,
// or serialises trap entry (mepc, mcause, mtval, mstatus) and mret over one port.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] INT_CAUSE = 32'h8000000B
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic            csr_rw_in,
  input  logic [1:0]      csr_wsc_in,
  input  logic [11:0]     csr_addr_in,
  input  logic [XLEN-1:0] csr_wdata_in,
  input  logic            ecall,
  input  logic            illegal_inst,
  input  logic            l_fault,
  input  logic            s_fault,
  input  logic            mret,
  input  logic            interrupt,
  input  logic [XLEN-1:0] pc_cur,
  input  logic [XLEN-1:0] pc_next,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] csr_rdata,
  output logic [11:0]     csr_raddr,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_w,
  output logic [1:0]      csr_wsc_mode,
  output logic            stall,
  output logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  state_e          state, state_next;
  logic            take, is_mret;
  logic [XLEN-1:0] cause_d, tval_d, epc_d;
  epc_sel_e        epc_sel;
  logic [XLEN-1:0] cause_q, epc_q, tval_q;
  logic [XLEN-1:0] trap_mstatus, mret_mstatus;

  trap_priority_enc #(.XLEN(XLEN), .INT_CAUSE(INT_CAUSE)) u_prio (
    .inst_valid   (inst_valid),
    .ecall        (ecall),
    .illegal_inst (illegal_inst),
    .l_fault      (l_fault),
    .s_fault      (s_fault),
    .mret         (mret),
    .interrupt    (interrupt),
    .mie          (mstatus[MIE_BIT]),
    .inst         (inst),
    .dmem_addr    (dmem_addr),
    .take         (take),
    .is_mret      (is_mret),
    .cause        (cause_d),
    .epc_sel      (epc_sel),
    .tval         (tval_d)
  );

  assign epc_d = (epc_sel == EPC_NEXT) ? pc_next : pc_cur;

  always_comb begin
    trap_mstatus                 = mstatus;
    trap_mstatus[MPIE_BIT]       = mstatus[MIE_BIT];
    trap_mstatus[MIE_BIT]        = 1'b0;
    trap_mstatus[MPP_HI:MPP_LO]  = 2'b11;
    mret_mstatus                 = mstatus;
    mret_mstatus[MIE_BIT]        = mstatus[MPIE_BIT];
    mret_mstatus[MPIE_BIT]       = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (state == IDLE && take && !is_mret) begin
        cause_q <= cause_d;
        epc_q   <= epc_d;
        tval_q  <= tval_d;
      end
    end
  end

  always_comb begin
    state_next   = state;
    csr_raddr    = csr_addr_in;
    csr_waddr    = csr_addr_in;
    csr_wdata    = csr_wdata_in;
    csr_wsc_mode = csr_wsc_in;
    csr_w        = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    if (state != IDLE) begin
      stall        = 1'b1;
      csr_w        = 1'b1;
      csr_wsc_mode = WSC_WRITE;
    end
    unique case (state)
      IDLE: begin
        // A detected event suppresses any CSR write carried by the same instruction.
        if (take) begin
          stall      = 1'b1;
          state_next = is_mret ? W_MRET : W_MEPC;
        end else begin
          csr_w = csr_rw_in & inst_valid;
        end
      end
      W_MEPC: begin
        csr_waddr  = CSR_MEPC;
        csr_wdata  = epc_q;
        state_next = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_waddr  = CSR_MCAUSE;
        csr_wdata  = cause_q;
        state_next = W_MTVAL;
      end
      W_MTVAL: begin
        csr_waddr  = CSR_MTVAL;
        csr_wdata  = tval_q;
        state_next = W_MSTATUS;
      end
      W_MSTATUS: begin
        csr_waddr   = CSR_MSTATUS;
        csr_wdata   = trap_mstatus;
        csr_raddr   = CSR_MTVEC;
        redirect    = 1'b1;
        flush       = 1'b1;
        redirect_pc = {csr_rdata[XLEN-1:2], 2'b00};
        state_next  = IDLE;
      end
      W_MRET: begin
        csr_waddr   = CSR_MSTATUS;
        csr_wdata   = mret_mstatus;
        csr_raddr   = CSR_MEPC;
        redirect    = 1'b1;
        flush       = 1'b1;
        redirect_pc = csr_rdata;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a small CSR-file model, a write/redirect scoreboard,
// an IDLE pass-through vector table and hand-built trap/mret/reset sequences.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, csr_rw_in, ecall, illegal_inst, l_fault, s_fault, mret, interrupt;
  logic [1:0]  csr_wsc_in;
  logic [11:0] csr_addr_in;
  logic [31:0] csr_wdata_in, pc_cur, pc_next, inst, dmem_addr, mstatus, csr_rdata;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;
  logic        csr_w, stall, flush, redirect;
  logic [1:0]  csr_wsc_mode;

  trap_sequencer #(.XLEN(32), .INT_CAUSE(32'h8000000B)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .csr_rw_in(csr_rw_in),
    .csr_wsc_in(csr_wsc_in), .csr_addr_in(csr_addr_in), .csr_wdata_in(csr_wdata_in),
    .ecall(ecall), .illegal_inst(illegal_inst), .l_fault(l_fault), .s_fault(s_fault),
    .mret(mret), .interrupt(interrupt), .pc_cur(pc_cur), .pc_next(pc_next), .inst(inst),
    .dmem_addr(dmem_addr), .mstatus(mstatus), .csr_rdata(csr_rdata), .csr_raddr(csr_raddr),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_w(csr_w), .csr_wsc_mode(csr_wsc_mode),
    .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_redirect = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // CSR file model
  logic [31:0] m_mstatus = '0, m_mtvec = '0, m_mepc = '0, m_mcause = '0, m_mtval = '0;

  function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] mode);
    case (mode)
      2'b01:   return d;
      2'b10:   return old | d;
      2'b11:   return old & ~d;
      default: return old;
    endcase
  endfunction

  always @(posedge clk) begin
    if (csr_w) begin
      case (csr_waddr)
        12'h300: m_mstatus <= apply(m_mstatus, csr_wdata, csr_wsc_mode);
        12'h305: m_mtvec   <= apply(m_mtvec,   csr_wdata, csr_wsc_mode);
        12'h341: m_mepc    <= apply(m_mepc,    csr_wdata, csr_wsc_mode);
        12'h342: m_mcause  <= apply(m_mcause,  csr_wdata, csr_wsc_mode);
        12'h343: m_mtval   <= apply(m_mtval,   csr_wdata, csr_wsc_mode);
        default: ;
      endcase
    end
  end

  assign mstatus = m_mstatus;

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      12'h342: csr_rdata = m_mcause;
      12'h343: csr_rdata = m_mtval;
      default: csr_rdata = '0;
    endcase
  end

  // Scoreboard
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  mode;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] rd_q[$];

  always @(negedge clk) begin
    if (csr_w) begin
      check("write_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", 32'(csr_waddr), 32'(e.addr));
        check("wr_data", csr_wdata, e.data);
        check("wr_mode", 32'(csr_wsc_mode), 32'(e.mode));
      end
    end
    if (redirect) begin
      n_redirect++;
      check("redirect_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) check("redirect_pc", redirect_pc, rd_q.pop_front());
      check("redirect_flush", 32'(flush), 32'd1);
    end
  end

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] m);
    wr_t e;
    e.addr = a; e.data = d; e.mode = m;
    wr_q.push_back(e);
  endtask

  task automatic push_trap(input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] mst,
                           input logic [31:0] target);
    push_wr(12'h341, epc, 2'b01);
    push_wr(12'h342, cause, 2'b01);
    push_wr(12'h343, tval, 2'b01);
    push_wr(12'h300, mst, 2'b01);
    rd_q.push_back(target);
  endtask

  task automatic clear_events();
    ecall = 0; illegal_inst = 0; l_fault = 0; s_fault = 0; mret = 0; interrupt = 0;
    csr_rw_in = 0;
  endtask

  // Called with the event already driven in detection cycle T; checks T..T+len.
  task automatic trap_seq(input string tag, input int len, input int inj);
    @(negedge clk);
    check({tag, "_det_stall"}, 32'(stall), 32'd1);
    check({tag, "_det_csr_w"}, 32'(csr_w), 32'd0);
    check({tag, "_det_redirect"}, 32'(redirect), 32'd0);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (k == 1) clear_events();
      if (k == inj) begin s_fault = 1; inst_valid = 1; dmem_addr = 32'h2000; end
      if (k == inj + 1) s_fault = 0;
      @(negedge clk);
      check($sformatf("%s_stall_t%0d", tag, k), 32'(stall), 32'd1);
      check($sformatf("%s_redirect_t%0d", tag, k), 32'(redirect), 32'(k == len));
      check($sformatf("%s_flush_t%0d", tag, k), 32'(flush), 32'(k == len));
    end
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    clear_events();
    inst_valid = 1; csr_rw_in = 1; csr_wsc_in = 2'b01; csr_addr_in = a; csr_wdata_in = d;
    push_wr(a, d, 2'b01);
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;
    logic        rw;
    logic [1:0]  wsc;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        ev;
    logic        exp_w;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 2'b10, 12'h300, 32'h8,      1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 2'b01, 12'h305, 32'h100,    1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 2'b01, 12'h7C0, 32'hABCD,   1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 2'b01, 12'h305, 32'hDEAD,   1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 12'h305, 32'h0,      1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 2'b01, 12'h300, 32'h0,      1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 2'b11, 12'h300, 32'h8,      1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 2'b01, 12'h300, 32'h88,     1'b0, 1'b1};

    rst = 1;
    inst_valid = 0; csr_wsc_in = 0; csr_addr_in = 0; csr_wdata_in = 0;
    pc_cur = 0; pc_next = 0; inst = 0; dmem_addr = 0;
    clear_events();
    @(negedge clk);
    check("rst_csr_w", 32'(csr_w), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_waddr", 32'(csr_waddr), 32'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_csr_w", 32'(csr_w), 32'd0);

    // IDLE pass-through table
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      clear_events();
      inst_valid = vecs[i].iv; csr_rw_in = vecs[i].rw; csr_wsc_in = vecs[i].wsc;
      csr_addr_in = vecs[i].addr; csr_wdata_in = vecs[i].wdata; ecall = vecs[i].ev;
      if (vecs[i].exp_w) push_wr(vecs[i].addr, vecs[i].wdata, vecs[i].wsc);
      @(negedge clk);
      check($sformatf("vec%0d_csr_w", i), 32'(csr_w), 32'(vecs[i].exp_w));
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      check($sformatf("vec%0d_raddr", i), 32'(csr_raddr), 32'(vecs[i].addr));
    end

    // Illegal instruction trap: mstatus 0x88, mtvec 0x100
    @(posedge clk); #1;
    clear_events();
    inst_valid = 1; illegal_inst = 1; pc_cur = 32'h40; inst = 32'hFFFFFFFF;
    push_trap(32'h40, 32'd2, 32'hFFFFFFFF, 32'h1880, 32'h100);
    trap_seq("illegal", 4, 0);

    // mret with mepc 0x44 and mstatus 0x1880
    csr_write(12'h341, 32'h44);
    @(posedge clk); #1;
    clear_events();
    inst_valid = 1; mret = 1;
    push_wr(12'h300, 32'h1888, 2'b01);
    rd_q.push_back(32'h44);
    trap_seq("mret", 1, 0);

    // Interrupt beats ecall when MIE=1
    @(posedge clk); #1;
    clear_events();
    inst_valid = 1; interrupt = 1; ecall = 1; pc_cur = 32'h50; pc_next = 32'h54;
    push_trap(32'h54, 32'h8000000B, 32'h0, 32'h1880, 32'h100);
    trap_seq("int_ecall", 4, 0);

    // MIE now 0: ecall wins; its CSR write is suppressed
    @(posedge clk); #1;
    clear_events();
    inst_valid = 1; interrupt = 1; ecall = 1; pc_cur = 32'h60; pc_next = 32'h64;
    csr_rw_in = 1; csr_wsc_in = 2'b01; csr_addr_in = 12'h7C0; csr_wdata_in = 32'hBAD;
    push_trap(32'h60, 32'd11, 32'h0, 32'h1800, 32'h100);
    trap_seq("masked_int", 4, 0);

    // ecall with a store fault injected during W_MCAUSE, then a back-to-back store fault
    @(posedge clk); #1;
    clear_events();
    inst_valid = 1; ecall = 1; pc_cur = 32'h70;
    push_trap(32'h70, 32'd11, 32'h0, 32'h1800, 32'h100);
    trap_seq("ecall_inj", 4, 2);
    @(posedge clk); #1;
    clear_events();
    inst_valid = 1; s_fault = 1; pc_cur = 32'h74; dmem_addr = 32'h2000;
    push_trap(32'h74, 32'd7, 32'h2000, 32'h1800, 32'h100);
    trap_seq("sfault", 4, 0);
    @(posedge clk); #1;
    clear_events();
    @(negedge clk);
    check("idle_after_stall", 32'(stall), 32'd0);
    check("idle_after_redirect", 32'(redirect), 32'd0);

    // Reset in T+2: only mepc is written
    csr_write(12'h342, 32'h5A5A);
    csr_write(12'h343, 32'h1234);
    @(posedge clk); #1;
    clear_events();
    inst_valid = 1; ecall = 1; pc_cur = 32'h90;
    push_wr(12'h341, 32'h90, 2'b01);
    @(negedge clk);
    check("rstseq_det_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    clear_events();
    @(negedge clk);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("rstseq_csr_w", 32'(csr_w), 32'd0);
    check("rstseq_stall", 32'(stall), 32'd0);
    check("rstseq_redirect", 32'(redirect), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (4) @(negedge clk);
    check("rstseq_mcause_kept", m_mcause, 32'h5A5A);
    check("rstseq_mtval_kept", m_mtval, 32'h1234);
    check("rstseq_mepc", m_mepc, 32'h90);

    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("redirect_count", 32'(n_redirect), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
